// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control slice: byte width and controller states.
package uart_ctrl_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  // IDLE selects/captures, SEND pulses the transmitter, ACK waits for busy, WAIT waits for idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ACK  = 2'd2,
    ST_WAIT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: grants the first requester after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 any
);

  localparam int unsigned ID_W = $clog2(N);

  logic [ID_W-1:0] idx;

  // Walk candidates ptr+1 .. ptr+N; modulo keeps non-power-of-two N correct.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = ID_W'((32'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any    = 1'b1;
        gnt_id = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmitter among N_REQ requesters.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = UART_BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]        tx_byte,
  output logic                     tx_send,
  input  logic                     tx_done,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     locked
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  arb_state_t        state, state_next;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   rr_ptr;
  logic              locked_q;
  logic              last_q;
  logic [DATA_W-1:0] tx_byte_q;

  logic [ID_W-1:0]   pick_id;
  logic              pick_any;
  logic              take;
  logic [ID_W-1:0]   take_id;
  logic [DATA_W-1:0] take_data;
  logic              take_last;
  logic [N_REQ-1:0]  ready_c;
  logic              send_c;

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Next-state, handshake and capture-source selection.
  always_comb begin
    state_next = state;
    ready_c    = '0;
    send_c     = 1'b0;
    take       = 1'b0;
    take_id    = grant_q;
    take_data  = '0;
    take_last  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A held grant never falls back to the picker, even if the owner stalls.
        if (locked_q) begin
          take    = req_valid[grant_q];
          take_id = grant_q;
        end else begin
          take    = pick_any;
          take_id = pick_id;
        end
        if (take) begin
          ready_c[take_id] = 1'b1;
          state_next       = ST_SEND;
        end
      end
      ST_SEND: begin
        send_c     = 1'b1;
        state_next = ST_ACK;
      end
      ST_ACK:  if (!tx_done) state_next = ST_WAIT;
      ST_WAIT: if (tx_done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == take_id) begin
        take_data = req_data[i*DATA_W +: DATA_W];
        take_last = req_last[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Capture on accept; release the lock and advance the pointer only at message end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte_q <= '0;
      last_q    <= 1'b0;
      grant_q   <= '0;
      locked_q  <= 1'b0;
      rr_ptr    <= ID_W'(N_REQ - 1);
    end else begin
      if (take) begin
        tx_byte_q <= take_data;
        last_q    <= take_last;
        grant_q   <= take_id;
        locked_q  <= 1'b1;
      end else if (state == ST_WAIT && tx_done && last_q) begin
        locked_q <= 1'b0;
        rr_ptr   <= grant_q;
      end
    end
  end

  // Ready is gated by reset so no handshake is offered while reset is asserted.
  assign req_ready = ready_c & {N_REQ{rst_n}};
  assign tx_send   = send_c;
  assign tx_byte   = tx_byte_q;
  assign grant_id  = grant_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a message-level reference model and a transmitter model.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_byte;
  logic           tx_send;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           locked;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_byte   (tx_byte),
    .tx_send   (tx_send),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester queues of {last, byte}, plus per-requester forced gaps.
  logic [8:0] q [N][$];
  int         hold_off [N];
  int         valid_pct = 100;
  bit         drop_owner1 = 1'b0;

  // Message-level model state.
  bit         m_locked, m_inflight, m_send_pend, m_last, m_rise;
  int         m_owner, m_rr;
  logic [7:0] m_byte;

  // Transmitter model: stays high tx_hi_wait cycles after the pulse, then low tx_lo_cnt cycles.
  int tx_hi_wait = -1;
  int tx_lo_cnt  = 0;

  int         acc_log  [$];
  logic [7:0] sent_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked    = 1'b0;
    m_inflight  = 1'b0;
    m_send_pend = 1'b0;
    m_last      = 1'b0;
    m_rise      = 1'b0;
    m_owner     = 0;
    m_rr        = N - 1;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  function automatic int acc_at(input int k);
    return (k < acc_log.size()) ? acc_log[k] : -1;
  endfunction

  function automatic int sent_at(input int k);
    return (k < sent_log.size()) ? int'(sent_log[k]) : -1;
  endfunction

  task automatic add_msg(input int r, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) q[r].push_back({(k == len - 1), 8'(base + 8'(k))});
  endtask

  // Registered outputs, sampled mid-cycle.
  task automatic observe();
    if (m_rise) begin
      m_rise     = 1'b0;
      m_inflight = 1'b0;
      if (m_last) begin
        m_locked = 1'b0;
        m_rr     = m_owner;
      end
    end
    check("locked", locked, m_locked);
    check("grant_id", grant_id, m_owner);
    if (m_send_pend) begin
      check("send_latency", tx_send, 1);
      check("tx_byte", tx_byte, m_byte);
      sent_log.push_back(tx_byte);
      m_send_pend = 1'b0;
    end else begin
      check("send_spurious", tx_send, 0);
    end
    if (tx_send === 1'b1) begin
      tx_hi_wait = $urandom_range(0, 3);
      tx_lo_cnt  = $urandom_range(2, 6);
    end
  endtask

  task automatic drive();
    logic [8:0] f;
    if (tx_hi_wait > 0) begin
      tx_hi_wait--;
    end else if (tx_hi_wait == 0) begin
      tx_done    = 1'b0;
      tx_hi_wait = -1;
    end else if (tx_lo_cnt > 0) begin
      tx_lo_cnt--;
      if (tx_lo_cnt == 0) begin
        tx_done = 1'b1;
        m_rise  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (hold_off[i] > 0) begin
        hold_off[i]--;
        req_valid[i] = 1'b0;
      end else if (q[i].size() > 0) begin
        f = q[i][0];
        req_valid[i]       = ($urandom_range(1, 100) <= valid_pct);
        req_data[i*8 +: 8] = f[7:0];
        req_last[i]        = f[8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  // Combinational handshake: which requester, if any, must be offered ready now.
  task automatic check_ready();
    logic [N-1:0] exp_rdy;
    logic [8:0]   f;
    int           pick;
    int           c;
    exp_rdy = '0;
    pick    = -1;
    if (rst_n && !m_inflight) begin
      if (m_locked) begin
        if (req_valid[m_owner]) pick = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_rr + k) % N;
          if (pick < 0 && req_valid[c]) pick = c;
        end
      end
    end
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (pick >= 0) begin
      check("tx_idle_at_accept", tx_done, 1);
      f           = q[pick].pop_front();
      m_byte      = f[7:0];
      m_last      = f[8];
      m_owner     = pick;
      m_locked    = 1'b1;
      m_inflight  = 1'b1;
      m_send_pend = 1'b1;
      acc_log.push_back(pick);
      if (drop_owner1 && pick == 1) begin
        hold_off[1] = 20;
        drop_owner1 = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    drive();
    #1;
    check_ready();
  endtask

  task automatic run_drain(input int budget);
    int c = 0;
    while ((pending() > 0 || m_inflight || m_send_pend) && c < budget) begin
      step();
      c++;
    end
    check("drain_timeout", (pending() > 0 || m_inflight || m_send_pend), 0);
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    sent_log.delete();
  endtask

  initial begin
    int c;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_done   = 1'b1;
    rst_n     = 1'b0;
    for (int i = 0; i < N; i++) hold_off[i] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_send", tx_send, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_grant_id", grant_id, 0);
    check("rst_locked", locked, 0);
    rst_n = 1'b1;

    // Requester 0 alone: "A","B".
    clear_logs();
    q[0].push_back({1'b0, 8'h41});
    q[0].push_back({1'b1, 8'h42});
    run_drain(200);
    check("p1_sends", sent_log.size(), 2);
    check("p1_byte0", sent_at(0), 32'h41);
    check("p1_byte1", sent_at(1), 32'h42);
    check("p1_unlocked", locked, 0);

    // Requesters 0 and 2 together after reset.
    do_reset();
    clear_logs();
    add_msg(0, 3, 8'h10);
    add_msg(2, 2, 8'h20);
    run_drain(400);
    check("p2_g0", acc_at(0), 0);
    check("p2_g1", acc_at(1), 0);
    check("p2_g2", acc_at(2), 0);
    check("p2_g3", acc_at(3), 2);

    // Owner 1 pauses 20 cycles mid-message while requester 3 waits.
    clear_logs();
    drop_owner1 = 1'b1;
    add_msg(1, 3, 8'h30);
    c = 0;
    while (!m_inflight && c < 50) begin step(); c++; end
    check("p3_owner_start", m_inflight, 1);
    add_msg(3, 1, 8'h3F);
    run_drain(400);
    check("p3_g0", acc_at(0), 1);
    check("p3_g1", acc_at(1), 1);
    check("p3_g2", acc_at(2), 1);
    check("p3_g3", acc_at(3), 3);

    // All four with back-to-back single-byte messages.
    do_reset();
    clear_logs();
    for (int r = 0; r < N; r++) begin
      add_msg(r, 1, 8'(8'h50 + 8'(r)));
      add_msg(r, 1, 8'(8'h60 + 8'(r)));
    end
    run_drain(600);
    for (int k = 0; k < 2 * N; k++) check("p4_rr_order", acc_at(k), k % N);

    // Random traffic with valid gaps and varied transmitter timing.
    valid_pct = 70;
    for (int b = 0; b < 4; b++) begin
      for (int m = 0; m < 8; m++)
        add_msg($urandom_range(0, N - 1), $urandom_range(1, 4), 8'($urandom));
      run_drain(3000);
    end
    valid_pct = 100;

    // Reset asserted while the controller sits in WAIT.
    clear_logs();
    add_msg(2, 2, 8'h70);
    c = 0;
    while (tx_done && c < 60) begin step(); c++; end
    check("p6_tx_busy", tx_done, 0);
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("p6_req_ready", req_ready, 0);
    check("p6_tx_send", tx_send, 0);
    check("p6_tx_byte", tx_byte, 8'h00);
    check("p6_grant_id", grant_id, 0);
    check("p6_locked", locked, 0);
    for (int i = 0; i < N; i++) q[i].delete();
    model_reset();
    c = 0;
    while ((tx_hi_wait >= 0 || tx_lo_cnt > 0) && c < 60) begin step(); c++; end
    model_reset();
    rst_n = 1'b1;
    clear_logs();
    add_msg(3, 1, 8'h7A);
    add_msg(0, 1, 8'h7B);
    run_drain(300);
    check("p6_restart_first", acc_at(0), 0);
    check("p6_restart_second", acc_at(1), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
